// File: rtl/sca_block_readout_seq_if.sv
// Request handshake between the trigger queue and the SCA block readout sequencer.
// The queue drives the master side; the sequencer is the slave and returns req_ready.
interface sca_block_readout_seq_if #(
  parameter int NSAMP = 8,
  parameter int BLKW  = 4,
  parameter int L1AW  = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [BLKW-1:0]  req_blk;
  logic [NSAMP-1:0] req_l1p;
  logic             req_nodata;
  logic [L1AW-1:0]  req_l1anum;

  modport master (
    output req_valid, req_blk, req_l1p, req_nodata, req_l1anum,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_blk, req_l1p, req_nodata, req_l1anum,
    output req_ready
  );
endinterface

// File: rtl/sca_block_readout_seq.sv
// SCA block readout sequencer: walks a sample bitmap, drives the ADC mux and emits FIFO strobes.
// Optional header word per block when RDOUT_HDR_EN is defined (adds the hdr output).
module sca_block_readout_seq #(
  parameter int NSAMP = 8,
  parameter int NCHAN = 16,
  parameter int BLKW  = 4,
  parameter int L1AW  = 6,
  parameter int PIPE  = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  sca_block_readout_seq_if.slave           req,
  input  logic                             hold,
  output logic                             rd_ena,
  output logic [BLKW+$clog2(NSAMP)-1:0]    adr,
  output logic [$clog2(NCHAN)-1:0]         ado,
  output logic                             push,
  output logic                             ndena,
  output logic                             lastword,
`ifdef RDOUT_HDR_EN
  output logic                             hdr,
`endif
  output logic [L1AW-1:0]                  l1anout,
  output logic                             busy,
  output logic                             blk_done,
  output logic [BLKW-1:0]                  sca_free_blk
);

  localparam int SW = $clog2(NSAMP);
  localparam int CW = $clog2(NCHAN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEEK  = 3'd1,
    ST_READ  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DRAIN = 3'd4,
`ifdef RDOUT_HDR_EN
    ST_HDR   = 3'd6,
`endif
    ST_DONE  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [SW-1:0]     s_r, s_s;
  logic [CW-1:0]     chan_r, chan_s;
  logic [NSAMP-1:0]  rem_r, rem_s;
  logic [NSAMP-1:0]  sel_bit_s;
  logic [BLKW-1:0]   blk_r;
  logic              nodata_r;
  logic [L1AW-1:0]   l1anout_r;

  logic              req_ready_s;
  logic              accept_s;
  logic              rdpad_s;
  logic              smp_last_s;
  logic              stb_s;
  logic              last_s;
  logic              pend_s;

  logic [PIPE-1:0]   stb_pipe_r;
  logic [PIPE-1:0]   nd_pipe_r;
  logic [PIPE-1:0]   last_pipe_r;

  logic              rd_ena_r;
  logic [BLKW+SW-1:0] adr_r;
  logic [CW-1:0]     ado_r;
  logic              busy_r;
  logic              blk_done_r;
  logic [BLKW-1:0]   sca_free_blk_r;

  assign req_ready_s   = (state_r == ST_IDLE);
  assign req.req_ready = req_ready_s;
  assign accept_s      = req.req_valid && req_ready_s;

  assign sel_bit_s  = NSAMP'(1'b1) << s_r;
  assign rdpad_s    = (state_r == ST_READ) || (state_r == ST_PAD);
  // The final strobe is the last channel of the only sample still flagged.
  assign smp_last_s = rdpad_s && (&chan_r) && ((rem_r & ~sel_bit_s) == '0);

`ifdef RDOUT_HDR_EN
  logic hdr_s;
  logic [PIPE-1:0] hdr_pipe_r;
  assign hdr_s  = (state_r == ST_HDR);
  assign stb_s  = rdpad_s || hdr_s;
  assign last_s = smp_last_s || (hdr_s && (rem_r == '0));
`else
  assign stb_s  = rdpad_s;
  assign last_s = smp_last_s;
`endif

  // Strobes still travelling toward the output stage; the stage holding PUSH is excluded.
  assign pend_s = |(stb_pipe_r << 1'b1);

  // Next-state and datapath-next logic for the readout walk.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    chan_s  = chan_r;
    rem_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef RDOUT_HDR_EN
          state_s = ST_HDR;
`else
          state_s = ST_SEEK;
`endif
          s_s    = '0;
          chan_s = '0;
          rem_s  = req.req_l1p;
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef RDOUT_HDR_EN
      ST_HDR: begin
        state_s = ST_SEEK;
      end
`endif
      ST_SEEK: begin
        if (rem_r == '0) begin
          state_s = ST_DRAIN;
        end else if ((rem_r & sel_bit_s) == '0) begin
          s_s = s_r + SW'(1'b1);
        end else if (hold) begin
          state_s = ST_SEEK;
        end else begin
          state_s = nodata_r ? ST_PAD : ST_READ;
          chan_s  = '0;
        end
      end
      ST_READ, ST_PAD: begin
        if (&chan_r) begin
          rem_s   = rem_r & ~sel_bit_s;
          s_s     = s_r + SW'(1'b1);
          chan_s  = '0;
          state_s = ST_SEEK;
        end else begin
          chan_s = chan_r + CW'(1'b1);
        end
      end
      ST_DRAIN: begin
        if (pend_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, captured request fields and registered mux/status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r        <= ST_IDLE;
      s_r            <= '0;
      chan_r         <= '0;
      rem_r          <= '0;
      blk_r          <= '0;
      nodata_r       <= 1'b0;
      l1anout_r      <= '0;
      rd_ena_r       <= 1'b0;
      adr_r          <= '0;
      ado_r          <= '0;
      busy_r         <= 1'b0;
      blk_done_r     <= 1'b0;
      sca_free_blk_r <= '0;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      chan_r  <= chan_s;
      rem_r   <= rem_s;
      if (accept_s) begin
        blk_r     <= req.req_blk;
        nodata_r  <= req.req_nodata;
        l1anout_r <= req.req_l1anum;
      end else begin
        blk_r     <= blk_r;
        nodata_r  <= nodata_r;
        l1anout_r <= l1anout_r;
      end
      rd_ena_r <= (state_s == ST_READ);
      if ((state_s == ST_READ) || (state_s == ST_PAD)) begin
        adr_r <= {blk_r, s_s};
        ado_r <= chan_s;
      end else begin
        adr_r <= '0;
        ado_r <= '0;
      end
      busy_r         <= (state_s != ST_IDLE);
      blk_done_r     <= (state_s == ST_DONE);
      sca_free_blk_r <= (state_s == ST_DONE) ? blk_r : '0;
    end
  end

  // Strobe pipeline: PUSH and its qualifiers emerge PIPE cycles after the strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stb_pipe_r  <= '0;
      nd_pipe_r   <= '0;
      last_pipe_r <= '0;
    end else begin
      stb_pipe_r  <= (stb_pipe_r << 1'b1)  | PIPE'(stb_s);
      nd_pipe_r   <= (nd_pipe_r << 1'b1)   | PIPE'(state_r == ST_PAD);
      last_pipe_r <= (last_pipe_r << 1'b1) | PIPE'(last_s);
    end
  end

`ifdef RDOUT_HDR_EN
  // Header marker travels alongside its strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hdr_pipe_r <= '0;
    end else begin
      hdr_pipe_r <= (hdr_pipe_r << 1'b1) | PIPE'(hdr_s);
    end
  end
  assign hdr = hdr_pipe_r[PIPE-1];
`endif

  assign push         = stb_pipe_r[PIPE-1];
  assign ndena        = nd_pipe_r[PIPE-1];
  assign lastword     = last_pipe_r[PIPE-1];
  assign rd_ena       = rd_ena_r;
  assign adr          = adr_r;
  assign ado          = ado_r;
  assign l1anout      = l1anout_r;
  assign busy         = busy_r;
  assign blk_done     = blk_done_r;
  assign sca_free_blk = sca_free_blk_r;

endmodule

// File: tb/tb_sca_block_readout_seq.sv
// Directed, table-driven bench for sca_block_readout_seq (NSAMP=8, NCHAN=16, PIPE=4).
module tb_sca_block_readout_seq;
  localparam int NSAMP = 8;
  localparam int NCHAN = 16;
  localparam int BLKW  = 4;
  localparam int L1AW  = 6;
  localparam int PIPE  = 4;
  localparam int SW    = 3;
  localparam int CW    = 4;
  localparam int MAXK  = 300;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 hold;
  logic                 rd_ena;
  logic [BLKW+SW-1:0]   adr;
  logic [CW-1:0]        ado;
  logic                 push, ndena, lastword, busy, blk_done;
  logic [L1AW-1:0]      l1anout;
  logic [BLKW-1:0]      sca_free_blk;
`ifdef RDOUT_HDR_EN
  logic                 hdr;
`endif

  sca_block_readout_seq_if #(.NSAMP(NSAMP), .BLKW(BLKW), .L1AW(L1AW)) req_if ();

  sca_block_readout_seq #(
    .NSAMP(NSAMP), .NCHAN(NCHAN), .BLKW(BLKW), .L1AW(L1AW), .PIPE(PIPE)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req_if), .hold(hold),
    .rd_ena(rd_ena), .adr(adr), .ado(ado), .push(push), .ndena(ndena),
    .lastword(lastword),
`ifdef RDOUT_HDR_EN
    .hdr(hdr),
`endif
    .l1anout(l1anout), .busy(busy), .blk_done(blk_done), .sca_free_blk(sca_free_blk)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int push_cnt = 0;

  always @(posedge CLK) begin
    if (push === 1'b1) push_cnt <= push_cnt + 1;
  end

  typedef struct {
    logic [BLKW-1:0]  blk;
    logic [NSAMP-1:0] l1p;
    logic             nodata;
    logic [L1AW-1:0]  l1anum;
    int               exp_push;
    int               exp_done;   // cycle index of BLK_DONE, accept edge = 0
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request at a negedge, accept on the next posedge, drop valid at the following negedge.
  task automatic send_req(input logic [BLKW-1:0] b, input logic [NSAMP-1:0] l1p,
                          input logic nd, input logic [L1AW-1:0] num);
    @(negedge CLK);
    check("req_ready_before_accept", req_if.req_ready, 1);
    req_if.req_valid  = 1'b1;
    req_if.req_blk    = b;
    req_if.req_l1p    = l1p;
    req_if.req_nodata = nd;
    req_if.req_l1anum = num;
    @(posedge CLK);
    @(negedge CLK);
    req_if.req_valid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit              stb [0:MAXK];
    int              smp [0:MAXK];
    int              chn [0:MAXK];
    bit [NSAMP-1:0]  rem;
    int              k;
    int              npush;
    bit              done_seen;
    bit              exp_push_now;
    for (int i = 0; i <= MAXK; i++) begin
      stb[i] = 1'b0; smp[i] = 0; chn[i] = 0;
    end
    // Expected strobe schedule: one SEEK per position, NCHAN strobes per flagged sample.
    rem = v.l1p;
    k = 1;
    for (int s = 0; s < NSAMP && rem != 0; s++) begin
      if (rem[s]) begin
        for (int c = 0; c < NCHAN; c++) begin
          stb[k+1+c] = 1'b1; smp[k+1+c] = s; chn[k+1+c] = c;
        end
        k += NCHAN + 1;
        rem[s] = 1'b0;
      end else begin
        k += 1;
      end
    end
    send_req(v.blk, v.l1p, v.nodata, v.l1anum);
    npush = 0;
    done_seen = 1'b0;
    for (k = 1; k <= MAXK && !done_seen; k++) begin
      if (k > 1) @(negedge CLK);
      check("rd_ena", rd_ena, stb[k] && !v.nodata);
      if (stb[k] && !v.nodata) begin
        check("adr", adr, {v.blk, SW'(smp[k])});
        check("ado", ado, chn[k]);
      end
      exp_push_now = (k > PIPE) ? stb[k-PIPE] : 1'b0;
      check("push", push, exp_push_now);
      if (push === 1'b1) begin
        npush++;
        check("ndena", ndena, v.nodata);
        check("lastword", lastword, npush == v.exp_push);
      end
      check("busy", busy, 1);
      check("l1anout", l1anout, v.l1anum);
      check("blk_done_time", blk_done, k == v.exp_done);
      if (blk_done === 1'b1) begin
        check("sca_free_blk", sca_free_blk, v.blk);
        done_seen = 1'b1;
      end
    end
    check("blk_done_seen", done_seen, 1);
    check("push_count", npush, v.exp_push);
    @(negedge CLK);
    check("blk_done_one_cycle", blk_done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", req_if.req_ready, 1);
  endtask

  initial begin
    int  n0;
    int  p0;
    bit  found;
    vecs[0] = '{blk: 4'd5,  l1p: 8'h06, nodata: 1'b0, l1anum: 6'd17, exp_push: 32,  exp_done: 40};
    vecs[1] = '{blk: 4'd3,  l1p: 8'h03, nodata: 1'b1, l1anum: 6'd42, exp_push: 32,  exp_done: 39};
    vecs[2] = '{blk: 4'd9,  l1p: 8'h00, nodata: 1'b0, l1anum: 6'd1,  exp_push: 0,   exp_done: 3};
    vecs[3] = '{blk: 4'd15, l1p: 8'h80, nodata: 1'b0, l1anum: 6'd63, exp_push: 16,  exp_done: 29};
    vecs[4] = '{blk: 4'd0,  l1p: 8'hFF, nodata: 1'b0, l1anum: 6'd5,  exp_push: 128, exp_done: 141};
    vecs[5] = '{blk: 4'd12, l1p: 8'h01, nodata: 1'b1, l1anum: 6'd33, exp_push: 16,  exp_done: 22};
    vecs[6] = '{blk: 4'd7,  l1p: 8'h00, nodata: 1'b1, l1anum: 6'd2,  exp_push: 0,   exp_done: 3};

    RST = 1'b1;
    hold = 1'b0;
    req_if.req_valid  = 1'b0;
    req_if.req_blk    = '0;
    req_if.req_l1p    = '0;
    req_if.req_nodata = 1'b0;
    req_if.req_l1anum = '0;

    // Reset held for two edges.
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_rd_ena", rd_ena, 0);
    check("rst_adr", adr, 0);
    check("rst_ado", ado, 0);
    check("rst_push", push, 0);
    check("rst_ndena", ndena, 0);
    check("rst_lastword", lastword, 0);
    check("rst_l1anout", l1anout, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_free_blk", sca_free_blk, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_ready_after", req_if.req_ready, 1);
    check("rst_busy_after", busy, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // HOLD raised mid-sample and kept across the sample boundary.
    p0 = push_cnt;
    send_req(4'd6, 8'h03, 1'b0, 6'd9);
    n0 = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rd_ena === 1'b1 && adr === {4'd6, 3'd0}) n0++;
      if (rd_ena === 1'b1 && ado === 4'd5) hold = 1'b1;
      if (rd_ena === 1'b1 && ado === 4'd15) found = 1'b1;
      else @(negedge CLK);
    end
    check("hold_sample0_end", found, 1);
    check("hold_sample0_reads", n0, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_no_read", rd_ena, 0);
    end
    hold = 1'b0;
    @(negedge CLK);
    check("hold_resume_rd", rd_ena, 1);
    check("hold_resume_adr", adr, {4'd6, 3'd1});
    check("hold_resume_ado", ado, 0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      if (blk_done === 1'b1) found = 1'b1;
    end
    check("hold_blk_done", found, 1);
    check("hold_free_blk", sca_free_blk, 6);
    check("hold_push_total", push_cnt - p0, 32);

    // Reset while reading channel 7.
    send_req(4'd2, 8'h01, 1'b0, 6'd11);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rd_ena === 1'b1 && ado === 4'd7) found = 1'b1;
      else @(negedge CLK);
    end
    check("rstmid_reached_ch7", found, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid_rd_ena", rd_ena, 0);
    check("rstmid_push", push, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_blk_done", blk_done, 0);
    check("rstmid_ready", req_if.req_ready, 1);
    RST = 1'b0;
    p0 = push_cnt;
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (blk_done === 1'b1) n0++;
    end
    check("rstmid_no_done", n0, 0);
    check("rstmid_no_push", push_cnt - p0, 0);

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
